branch_predict_resolve: RTL

BRANCH_PREDICT_RESOLVE -- requirements
Module: branch_predict_resolve

---
 rtl/branch_predict_resolve.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/branch_predict_resolve.sv
// +------------------------------------------------------------------------+
// | branch_predict_resolve                                                 |
// | 2-bit PHT predictor with single-cycle branch resolution and counters.  |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

module branch_predict_resolve #(
  parameter int ADDR_W    = 32,
  parameter int PHT_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flag_we,
  input  logic              alu_zero,
  input  logic              alu_sign,
  input  logic              alu_carry,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              pred_taken,
  input  logic              res_valid,
  input  logic [5:0]        res_opcode,
  input  logic [ADDR_W-1:0] res_pc,
  input  logic [ADDR_W-1:0] res_target,
  input  logic              res_pred_taken,
  output logic              out_valid,
  output logic              out_taken,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [15:0]       branch_cnt,
  output logic [15:0]       mispred_cnt
);

  localparam int IDX_W = $clog2(PHT_DEPTH);

  localparam logic [5:0] c_OP_JMP_A = 6'b101011;
  localparam logic [5:0] c_OP_JMP_B = 6'b101000;
  localparam logic [5:0] c_OP_JMP_C = 6'b100000;
  localparam logic [5:0] c_OP_BZ    = 6'b110001;
  localparam logic [5:0] c_OP_BNZ   = 6'b110010;
  localparam logic [5:0] c_OP_BS    = 6'b110000;
  localparam logic [5:0] c_OP_BC    = 6'b101001;
  localparam logic [5:0] c_OP_BNC   = 6'b101010;

  // flags_q = {Z, S, C}
  logic [2:0]                  flags_q, flags_d;
  logic [PHT_DEPTH-1:0][1:0]   pht_q, pht_d;
  logic                        out_valid_q, out_valid_d;
  logic                        out_taken_q, out_taken_d;
  logic                        mispredict_q, mispredict_d;
  logic [ADDR_W-1:0]           redirect_pc_q, redirect_pc_d;
  logic [15:0]                 branch_cnt_q, branch_cnt_d;
  logic [15:0]                 mispred_cnt_q, mispred_cnt_d;

  logic             w_is_cond;
  logic             w_is_uncond;
  logic             w_cond_taken;
  logic             w_taken;
  logic             w_mispredict;
  logic [IDX_W-1:0] w_fetch_idx;
  logic [IDX_W-1:0] w_res_idx;
  logic [1:0]       w_res_ctr;
  logic             w_unused_fetch;

  assign w_fetch_idx    = fetch_pc[IDX_W+1:2];
  assign w_res_idx      = res_pc[IDX_W+1:2];
  assign w_res_ctr      = pht_q[w_res_idx];
  assign w_unused_fetch = ^fetch_pc;

  // Reads the registered table, so a same-index resolve is not yet visible.
  assign pred_taken = pht_q[w_fetch_idx][1];

  always_comb begin
    w_is_cond    = 1'b0;
    w_is_uncond  = 1'b0;
    w_cond_taken = 1'b0;
    case (res_opcode)
      c_OP_JMP_A, c_OP_JMP_B, c_OP_JMP_C: w_is_uncond = 1'b1;
      c_OP_BZ:  begin w_is_cond = 1'b1; w_cond_taken = flags_q[2];  end
      c_OP_BNZ: begin w_is_cond = 1'b1; w_cond_taken = ~flags_q[2]; end
      c_OP_BS:  begin w_is_cond = 1'b1; w_cond_taken = flags_q[1];  end
      c_OP_BC:  begin w_is_cond = 1'b1; w_cond_taken = flags_q[0];  end
      c_OP_BNC: begin w_is_cond = 1'b1; w_cond_taken = ~flags_q[0]; end
      default: ;
    endcase
  end

  assign w_taken      = w_is_uncond | (w_is_cond & w_cond_taken);
  assign w_mispredict = w_taken ^ res_pred_taken;

  always_comb begin
    flags_d       = flag_we ? {alu_zero, alu_sign, alu_carry} : flags_q;
    pht_d         = pht_q;
    out_valid_d   = res_valid;
    mispredict_d  = res_valid & w_mispredict;
    out_taken_d   = res_valid ? w_taken : out_taken_q;
    redirect_pc_d = redirect_pc_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;

    if (res_valid) begin
      redirect_pc_d = w_taken ? res_target : res_pc + ADDR_W'(4);
      if (w_is_cond) begin
        if (w_taken && w_res_ctr != 2'b11)
          pht_d[w_res_idx] = w_res_ctr + 2'd1;
        else if (!w_taken && w_res_ctr != 2'b00)
          pht_d[w_res_idx] = w_res_ctr - 2'd1;
      end
      if ((w_is_cond || w_is_uncond) && branch_cnt_q != 16'hFFFF)
        branch_cnt_d = branch_cnt_q + 16'd1;
      if (w_mispredict && mispred_cnt_q != 16'hFFFF)
        mispred_cnt_d = mispred_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q       <= 3'b000;
      pht_q         <= {PHT_DEPTH{2'b01}};
      out_valid_q   <= 1'b0;
      out_taken_q   <= 1'b0;
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
      branch_cnt_q  <= 16'd0;
      mispred_cnt_q <= 16'd0;
    end else begin
      flags_q       <= flags_d;
      pht_q         <= pht_d;
      out_valid_q   <= out_valid_d;
      out_taken_q   <= out_taken_d;
      mispredict_q  <= mispredict_d;
      redirect_pc_q <= redirect_pc_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_taken   = out_taken_q;
  assign mispredict  = mispredict_q;
  assign redirect_pc = redirect_pc_q;
  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

`default_nettype wire
